// File: rtl/cci_mpf_prim_pkg.sv
// Shared constants for the MPF buffering primitives.
package cci_mpf_prim_pkg;

    // Deepest BRAM read pipeline the primitives are built to hide
    localparam int unsigned MPF_PRIM_MAX_READ_LATENCY = 3;

endpackage

// File: rtl/cci_mpf_prim_ram_sdp.sv
// Simple dual-port block RAM: one write port, one read port with a fixed
// read latency of READ_LATENCY cycles from address to data.
module cci_mpf_prim_ram_sdp #(
    parameter int unsigned N_WORDS      = 64,
    parameter int unsigned N_DATA_BITS  = 32,
    parameter int unsigned ADDR_BITS    = 6,
    parameter int unsigned READ_LATENCY = 2
) (
    input  logic                   clk,
    input  logic                   wen,
    input  logic [ADDR_BITS-1:0]   waddr,
    input  logic [N_DATA_BITS-1:0] wdata,
    input  logic [ADDR_BITS-1:0]   raddr,
    output logic [N_DATA_BITS-1:0] rdata
);

    logic [N_DATA_BITS-1:0] mem     [N_WORDS];
    logic [N_DATA_BITS-1:0] rd_pipe [READ_LATENCY];

    // Write port; contents are never cleared
    always_ff @(posedge clk) begin
        if (wen) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port: array read plus optional output register stages
    always_ff @(posedge clk) begin
        rd_pipe[0] <= mem[raddr];
        for (int k = 1; k < int'(READ_LATENCY); k++) begin
            rd_pipe[k] <= rd_pipe[k-1];
        end
    end

    assign rdata = rd_pipe[READ_LATENCY-1];

endmodule

// File: rtl/cci_mpf_prim_fifo_bram_lat.sv
// Showahead FIFO in block RAM. A small register FIFO in front of the BRAM
// hides the read latency so the head is visible whenever notEmpty is set,
// and keeps enough reads in flight to sustain one enq and one deq per cycle.
module cci_mpf_prim_fifo_bram_lat
    import cci_mpf_prim_pkg::*;
#(
    parameter int unsigned N_DATA_BITS     = 32,
    parameter int unsigned N_ENTRIES       = 64,
    parameter int unsigned THRESHOLD       = 1,
    parameter int unsigned EMPTY_THRESHOLD = 1,
    parameter int unsigned READ_LATENCY    = 2
) (
    input  logic                             clk,
    input  logic                             reset,

    input  logic [N_DATA_BITS-1:0]           enq_data,
    input  logic                             enq_en,
    output logic                             notFull,
    output logic                             almostFull,

    output logic [N_DATA_BITS-1:0]           first,
    input  logic                             deq_en,
    output logic                             notEmpty,
    output logic                             almostEmpty,

    output logic [$clog2(N_ENTRIES+1)-1:0]   count
);

    localparam int unsigned IDX_BITS    = $clog2(N_ENTRIES);
    localparam int unsigned CNT_BITS    = $clog2(N_ENTRIES + 1);
    localparam int unsigned OUT_DEPTH   = READ_LATENCY + 1;
    localparam int unsigned OB_PTR_BITS = $clog2(OUT_DEPTH);
    localparam int unsigned OB_CNT_BITS = $clog2(OUT_DEPTH + 1);

    // Reject configurations the prefetch scheme cannot cover
    if (READ_LATENCY < 1 || READ_LATENCY > MPF_PRIM_MAX_READ_LATENCY || N_ENTRIES < 2) begin : g_param_check
        $error("cci_mpf_prim_fifo_bram_lat: illegal READ_LATENCY or N_ENTRIES");
    end

    logic [IDX_BITS-1:0]     wr_idx;
    logic [IDX_BITS-1:0]     rd_idx;
    logic [CNT_BITS-1:0]     cnt_q;
    logic [CNT_BITS-1:0]     bram_cnt;
    logic [READ_LATENCY-1:0] vld_pipe;
    logic [OB_PTR_BITS-1:0]  ob_head;
    logic [OB_PTR_BITS-1:0]  ob_tail;
    logic [OB_CNT_BITS-1:0]  ob_cnt;
    logic [OB_CNT_BITS-1:0]  ob_cnt_nxt;
    logic [OB_CNT_BITS-1:0]  in_flight;
    logic                    ne_q;
    logic [N_DATA_BITS-1:0]  obuf [OUT_DEPTH];
    logic [N_DATA_BITS-1:0]  ram_rdata;

    logic        enq_ok;
    logic        deq_ok;
    logic        issue;
    logic        ret;
    int unsigned occ_after;

    function automatic logic [IDX_BITS-1:0] nxt_idx(input logic [IDX_BITS-1:0] i);
        return (i == IDX_BITS'(N_ENTRIES - 1)) ? '0 : i + IDX_BITS'(1);
    endfunction

    function automatic logic [OB_PTR_BITS-1:0] nxt_ob(input logic [OB_PTR_BITS-1:0] p);
        return (p == OB_PTR_BITS'(OUT_DEPTH - 1)) ? '0 : p + OB_PTR_BITS'(1);
    endfunction

    // Status flags decoded from the registered occupancy
    assign notFull     = (cnt_q < CNT_BITS'(N_ENTRIES));
    assign almostFull  = ((N_ENTRIES - 32'(cnt_q)) <= THRESHOLD);
    assign almostEmpty = (32'(cnt_q) <= EMPTY_THRESHOLD);
    assign count       = cnt_q;
    assign notEmpty    = ne_q;
    assign first       = obuf[ob_head];

    assign enq_ok = enq_en && notFull;
    assign deq_ok = deq_en && ne_q;
    assign ret    = vld_pipe[READ_LATENCY-1];

    // Reads already committed to the output buffer but not yet landed
    always_comb begin
        in_flight = '0;
        for (int k = 0; k < int'(READ_LATENCY); k++) begin
            in_flight = in_flight + OB_CNT_BITS'(vld_pipe[k]);
        end
    end

    // Issue a BRAM read only if its data is guaranteed a buffer slot on return
    always_comb begin
        occ_after  = 32'(ob_cnt) + 32'(in_flight) - 32'(deq_ok);
        issue      = (bram_cnt != '0) && (occ_after < OUT_DEPTH);
        ob_cnt_nxt = ob_cnt + OB_CNT_BITS'(ret) - OB_CNT_BITS'(deq_ok);
    end

    // Control state: indices, counters, read-valid pipeline, buffer pointers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_idx   <= '0;
            rd_idx   <= '0;
            cnt_q    <= '0;
            bram_cnt <= '0;
            vld_pipe <= '0;
            ob_head  <= '0;
            ob_tail  <= '0;
            ob_cnt   <= '0;
            ne_q     <= 1'b0;
        end else begin
            if (enq_ok) begin
                wr_idx <= nxt_idx(wr_idx);
            end
            if (issue) begin
                rd_idx <= nxt_idx(rd_idx);
            end
            cnt_q    <= cnt_q + CNT_BITS'(enq_ok) - CNT_BITS'(deq_ok);
            bram_cnt <= bram_cnt + CNT_BITS'(enq_ok) - CNT_BITS'(issue);
            vld_pipe[0] <= issue;
            for (int k = 1; k < int'(READ_LATENCY); k++) begin
                vld_pipe[k] <= vld_pipe[k-1];
            end
            if (ret) begin
                ob_tail <= nxt_ob(ob_tail);
            end
            if (deq_ok) begin
                ob_head <= nxt_ob(ob_head);
            end
            ob_cnt <= ob_cnt_nxt;
            ne_q   <= (ob_cnt_nxt != '0);
        end
    end

    // Prefetch buffer storage; returning read data lands at the tail
    always_ff @(posedge clk) begin
        if (ret) begin
            obuf[ob_tail] <= ram_rdata;
        end
    end

    // Payload storage
    cci_mpf_prim_ram_sdp #(
        .N_WORDS      (N_ENTRIES),
        .N_DATA_BITS  (N_DATA_BITS),
        .ADDR_BITS    (IDX_BITS),
        .READ_LATENCY (READ_LATENCY)
    ) u_ram (
        .clk   (clk),
        .wen   (enq_ok),
        .waddr (wr_idx),
        .wdata (enq_data),
        .raddr (rd_idx),
        .rdata (ram_rdata)
    );

`ifndef SYNTHESIS
    // Protocol checks: callers must honour notFull and notEmpty
    always @(posedge clk) begin
        if (!reset) begin
            assert (!(enq_en && !notFull)) else $fatal(1, "cci_mpf_prim_fifo_bram_lat: enq while full");
            assert (!(deq_en && !notEmpty)) else $fatal(1, "cci_mpf_prim_fifo_bram_lat: deq while empty");
        end
    end
`endif

endmodule
